// File: rtl/jvm_xlate_seq_if.sv
// ---------------------------------------------------------------------------
// jvm_xlate_seq_if
//   Byte-stream input and ARM-word output handshakes of the JVM->ARM
//   translation sequencer.
//   slave  : translator view (consumes bytes, produces words)
//   master : surrounding-system view (bytecode reader / ARM word writer)
//   in_valid/in_ready/in_byte       : bytecode byte stream
//   out_valid/out_ready/out_word/out_last : emitted ARM instruction words
// ---------------------------------------------------------------------------
interface jvm_xlate_seq_if #(
  parameter int ARM_W = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_byte;
  logic             out_valid;
  logic             out_ready;
  logic [ARM_W-1:0] out_word;
  logic             out_last;

  modport slave (
    input  in_valid, in_byte, out_ready,
    output in_ready, out_valid, out_word, out_last
  );

  modport master (
    output in_valid, in_byte, out_ready,
    input  in_ready, out_valid, out_word, out_last
  );
endinterface

// File: rtl/jvm_xlate_seq.sv
// ---------------------------------------------------------------------------
// jvm_xlate_seq
//   Consumes a JVM bytecode stream, resolves the `wide` prefix, collects a
//   per-opcode number of operand bytes, then walks a template ROM linked list
//   and emits ARM words with operand bytes spliced in.
// Ports:
//   clk, reset     : clock (rising edge), asynchronous active-low reset
//   bus            : byte input / word output handshakes (slave modport)
//   desc_addr/data : descriptor ROM, data = {param_count, entry_ptr}, read
//                    in the cycle after desc_addr changes
//   tmpl_addr/data : template ROM, data = {last, insert, pidx, word}, read
//                    in the cycle after tmpl_addr changes
//   illegal        : one-cycle pulse on illegal opcode or double `wide`
//   busy           : high outside IDLE/FETCH_OP
// ARM_W is expected to be >= 16 (a wide splice replaces the low 16 bits).
// ---------------------------------------------------------------------------
module jvm_xlate_seq #(
  parameter int         ADDR_W      = 9,
  parameter int         ARM_W       = 32,
  parameter int         MAX_PARAMS  = 4,
  parameter int         PCNT_W      = 3,
  parameter logic [7:0] WIDE_OPCODE = 8'hC4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  jvm_xlate_seq_if.slave                            bus,
  output logic [7:0]                                desc_addr,
  input  logic [PCNT_W+ADDR_W-1:0]                  desc_data,
  output logic [ADDR_W-1:0]                         tmpl_addr,
  input  logic [ARM_W+2+$clog2(2*MAX_PARAMS)-1:0]   tmpl_data,
  output logic                                      illegal,
  output logic                                      busy
);

  localparam int BUF_N  = 2 * MAX_PARAMS;
  localparam int PIDX_W = $clog2(BUF_N);
  localparam int IDX_W  = $clog2(BUF_N + 1);
  localparam int BUF_D  = 1 << PIDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_OP, S_DESC, S_PARAMS, S_TMPL_RD, S_EMIT
  } state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [ARM_W-1:0]   out_word_q, out_word_d;
  logic               out_last_q, out_last_d;
  logic               illegal_q, illegal_d;
  logic               busy_q, busy_d;
  logic [7:0]         desc_addr_q, desc_addr_d;
  logic [ADDR_W-1:0]  tmpl_addr_q, tmpl_addr_d;
  logic [ADDR_W-1:0]  entry_q, entry_d;
  logic               wide_q, wide_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   need_q, need_d;
  logic [7:0]         buf_q [BUF_D];
  logic [7:0]         buf_d [BUF_D];

  // ROM field views
  logic [PCNT_W-1:0]  d_pcnt;
  logic [ADDR_W-1:0]  d_entry;
  logic               t_last, t_insert;
  logic [PIDX_W-1:0]  t_pidx, t_pidx_nxt;
  logic [ARM_W-1:0]   t_word;
  logic [IDX_W-1:0]   need_w;
  logic               accept;

  assign d_entry  = desc_data[ADDR_W-1:0];
  assign d_pcnt   = desc_data[PCNT_W+ADDR_W-1:ADDR_W];
  assign t_word   = tmpl_data[ARM_W-1:0];
  assign t_pidx   = tmpl_data[ARM_W +: PIDX_W];
  assign t_insert = tmpl_data[ARM_W+PIDX_W];
  assign t_last   = tmpl_data[ARM_W+PIDX_W+1];
  // Second byte of a wide operand wraps within the operand buffer.
  assign t_pidx_nxt = (t_pidx == PIDX_W'(BUF_N - 1)) ? '0 : t_pidx + 1'b1;
  assign accept   = bus.in_valid && in_ready_q;

  // NOTE: combinational next-state logic uses blocking assignments and gives
  // every _d signal a default first, so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    out_word_d  = out_word_q;
    out_last_d  = out_last_q;
    illegal_d   = 1'b0;
    desc_addr_d = desc_addr_q;
    tmpl_addr_d = tmpl_addr_q;
    entry_d     = entry_q;
    wide_d      = wide_q;
    idx_d       = idx_q;
    need_d      = need_q;
    buf_d       = buf_q;
    need_w      = wide_q ? IDX_W'({d_pcnt, 1'b0}) : IDX_W'(d_pcnt);

    unique case (state_q)
      S_IDLE: state_d = S_FETCH_OP;

      S_FETCH_OP: begin
        if (accept) begin
          if (bus.in_byte == WIDE_OPCODE) begin
            // A second prefix in a row is illegal and cancels the first.
            illegal_d = wide_q;
            wide_d    = !wide_q;
          end else begin
            desc_addr_d = bus.in_byte;
            state_d     = S_DESC;
          end
        end
      end

      S_DESC: begin
        if (d_entry == '0) begin
          illegal_d = 1'b1;
          wide_d    = 1'b0;
          state_d   = S_FETCH_OP;
        end else begin
          entry_d = d_entry;
          need_d  = need_w;
          if (need_w == '0) begin
            tmpl_addr_d = d_entry;
            state_d     = S_TMPL_RD;
          end else begin
            state_d = S_PARAMS;
          end
        end
      end

      S_PARAMS: begin
        if (accept) begin
          buf_d[idx_q[PIDX_W-1:0]] = bus.in_byte;
          idx_d = idx_q + 1'b1;
          if (idx_d == need_q) begin
            tmpl_addr_d = entry_q;
            state_d     = S_TMPL_RD;
          end
        end
      end

      S_TMPL_RD: begin
        if (!t_insert)
          out_word_d = t_word;
        else if (!wide_q)
          out_word_d = {t_word[ARM_W-1:8], buf_q[t_pidx]};
        else
          out_word_d = {t_word[ARM_W-1:16], buf_q[t_pidx], buf_q[t_pidx_nxt]};
        out_last_d = t_last;
        state_d    = S_EMIT;
      end

      S_EMIT: begin
        if (bus.out_ready) begin
          if (out_last_q) begin
            wide_d  = 1'b0;
            idx_d   = '0;
            state_d = S_FETCH_OP;
          end else begin
            tmpl_addr_d = tmpl_addr_q + 1'b1;
            state_d     = S_TMPL_RD;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Handshake strobes are registered from the state being entered.
    in_ready_d  = (state_d == S_FETCH_OP) || (state_d == S_PARAMS);
    out_valid_d = (state_d == S_EMIT);
    busy_d      = !((state_d == S_IDLE) || (state_d == S_FETCH_OP));
  end

  // NOTE: the operand buffer is a handful of flops, so it is cleared by reset
  // like everything else; stale reads after reset then return zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_last_q  <= 1'b0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
      desc_addr_q <= '0;
      tmpl_addr_q <= '0;
      entry_q     <= '0;
      wide_q      <= 1'b0;
      idx_q       <= '0;
      need_q      <= '0;
      buf_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_last_q  <= out_last_d;
      illegal_q   <= illegal_d;
      busy_q      <= busy_d;
      desc_addr_q <= desc_addr_d;
      tmpl_addr_q <= tmpl_addr_d;
      entry_q     <= entry_d;
      wide_q      <= wide_d;
      idx_q       <= idx_d;
      need_q      <= need_d;
      buf_q       <= buf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_last  = out_last_q;
  assign desc_addr     = desc_addr_q;
  assign tmpl_addr     = tmpl_addr_q;
  assign illegal       = illegal_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_jvm_xlate_seq.sv
// ---------------------------------------------------------------------------
// tb_jvm_xlate_seq
//   Directed bench for jvm_xlate_seq. Descriptor and template ROMs are
//   modelled as combinational lookups on the DUT's registered addresses.
//   Expected output words are pushed into a queue when a byte stream is
//   issued; a monitor pops and compares on every accepted output word.
// ---------------------------------------------------------------------------
module tb_jvm_xlate_seq;
  localparam int ADDR_W = 9;
  localparam int ARM_W  = 32;
  localparam int PCNT_W = 3;
  localparam int TMPL_W = ARM_W + 2 + 3;

  typedef struct packed {
    logic [ARM_W-1:0] word;
    logic             last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0]               desc_addr;
  logic [PCNT_W+ADDR_W-1:0] desc_data;
  logic [ADDR_W-1:0]        tmpl_addr;
  logic [TMPL_W-1:0]        tmpl_data;
  logic illegal, busy;

  logic [PCNT_W+ADDR_W-1:0] desc_rom [256];
  logic [TMPL_W-1:0]        tmpl_rom [512];

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;
  int illegal_cycles = 0;

  jvm_xlate_seq_if #(.ARM_W(ARM_W)) bus ();

  jvm_xlate_seq #(
    .ADDR_W(ADDR_W), .ARM_W(ARM_W), .MAX_PARAMS(4), .PCNT_W(PCNT_W),
    .WIDE_OPCODE(8'hC4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .desc_addr(desc_addr), .desc_data(desc_data),
    .tmpl_addr(tmpl_addr), .tmpl_data(tmpl_data),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  assign desc_data = desc_rom[desc_addr];
  assign tmpl_data = tmpl_rom[tmpl_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [TMPL_W-1:0] mk_t(input logic last, input logic ins,
                                              input logic [2:0] pidx, input logic [31:0] w);
    return {last, ins, pidx, w};
  endfunction

  // Monitor: compares every accepted word against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      if (illegal) illegal_cycles++;
      if (bus.out_valid) check("in_ready_vs_out_valid", bus.in_ready, 1'b0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %h with no word expected", bus.out_word);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_word", bus.out_word, e.word);
          check("out_last", bus.out_last, e.last);
        end
      end
    end
  end

  // Stimulus is applied 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) timeout("send_byte");
  endtask

  task automatic push(input logic [31:0] w, input logic last);
    exp_t e;
    e.word = w;
    e.last = last;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (sb_q.size() == 0 && bus.in_ready && !busy) done = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) timeout(name);
  endtask

  task automatic wait_out_valid(input string name);
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.out_valid) done = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) timeout(name);
  endtask

  initial begin
    int ill0;
    for (int i = 0; i < 256; i++) desc_rom[i] = '0;
    for (int i = 0; i < 512; i++) tmpl_rom[i] = '0;
    desc_rom[8'h60] = {3'd0, 9'd5};
    desc_rom[8'h10] = {3'd1, 9'd7};
    desc_rom[8'h15] = {3'd1, 9'd9};
    desc_rom[8'h20] = {3'd2, 9'd11};
    desc_rom[8'h30] = {3'd4, 9'd13};
    desc_rom[8'h40] = {3'd0, 9'd511};
    tmpl_rom[5]   = mk_t(1'b0, 1'b0, 3'd0, 32'hE0800001);
    tmpl_rom[6]   = mk_t(1'b1, 1'b0, 3'd0, 32'hE52D0004);
    tmpl_rom[7]   = mk_t(1'b1, 1'b1, 3'd0, 32'hE3A00000);
    tmpl_rom[9]   = mk_t(1'b1, 1'b1, 3'd0, 32'hE3000000);
    tmpl_rom[11]  = mk_t(1'b0, 1'b1, 3'd1, 32'hE1A00000);
    tmpl_rom[12]  = mk_t(1'b1, 1'b1, 3'd0, 32'hE2800000);
    tmpl_rom[13]  = mk_t(1'b1, 1'b1, 3'd7, 32'hE5900000);
    tmpl_rom[511] = mk_t(1'b0, 1'b0, 3'd0, 32'hAAAA5555);
    tmpl_rom[0]   = mk_t(1'b1, 1'b0, 3'd0, 32'h12345678);

    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.out_ready = 1'b1;

    // Reset held for three cycles, outputs at reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_word", bus.out_word, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_illegal", illegal, 0);
    check("rst_busy", busy, 0);
    check("rst_desc_addr", desc_addr, 0);
    check("rst_tmpl_addr", tmpl_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("idle_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    check("fetch_in_ready", bus.in_ready, 1);
    check("fetch_busy", busy, 0);

    // Zero-operand opcode, two template words, latency check.
    push(32'hE0800001, 1'b0);
    push(32'hE52D0004, 1'b1);
    send_byte(8'h60);
    check("lat_desc_addr", desc_addr, 8'h60);
    check("lat_busy", busy, 1);
    check("lat_c1_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_c2_valid", bus.out_valid, 0);
    check("lat_tmpl_addr", tmpl_addr, 5);
    @(posedge clk);
    #1;
    check("lat_c3_valid", bus.out_valid, 1);
    wait_idle("zero_op");

    // Single operand splice.
    push(32'hE3A0007F, 1'b1);
    send_byte(8'h10);
    send_byte(8'h7F);
    wait_idle("splice");

    // Wide operand, then a plain opcode proves the prefix was cleared.
    push(32'hE3000102, 1'b1);
    send_byte(8'hC4);
    send_byte(8'h15);
    send_byte(8'h01);
    send_byte(8'h02);
    wait_idle("wide");
    push(32'hE3A00033, 1'b1);
    send_byte(8'h10);
    send_byte(8'h33);
    wait_idle("wide_cleared");

    // Two operands read out of order.
    push(32'hE1A000BB, 1'b0);
    push(32'hE28000AA, 1'b1);
    send_byte(8'h20);
    send_byte(8'hAA);
    send_byte(8'hBB);
    wait_idle("two_ops");

    // Wide with pidx at the top of the buffer: second byte wraps to index 0.
    push(32'hE5908811, 1'b1);
    send_byte(8'hC4);
    send_byte(8'h30);
    for (int i = 1; i <= 8; i++) send_byte(8'(8'h11 * i));
    wait_idle("wide_wrap");

    // Template address wraps from 511 to 0.
    push(32'hAAAA5555, 1'b0);
    push(32'h12345678, 1'b1);
    send_byte(8'h40);
    wait_idle("tmpl_wrap");

    // Back-pressure for five cycles during EMIT.
    bus.out_ready = 1'b0;
    push(32'hE0800001, 1'b0);
    push(32'hE52D0004, 1'b1);
    send_byte(8'h60);
    wait_out_valid("bp_wait");
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", bus.out_valid, 1);
      check("bp_word", bus.out_word, 32'hE0800001);
      check("bp_tmpl_addr", tmpl_addr, 5);
      check("bp_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_idle("bp_drain");

    // Double wide prefix.
    ill0 = illegal_cycles;
    send_byte(8'hC4);
    send_byte(8'hC4);
    repeat (3) @(posedge clk);
    #1;
    check("dbl_wide_pulses", illegal_cycles - ill0, 1);
    check("dbl_wide_ready", bus.in_ready, 1);
    push(32'hE3A00055, 1'b1);
    send_byte(8'h10);
    send_byte(8'h55);
    wait_idle("after_dbl_wide");

    // Illegal opcode, plain and after a wide prefix; no words expected.
    ill0 = illegal_cycles;
    send_byte(8'hFF);
    repeat (3) @(posedge clk);
    #1;
    check("ill_op_pulses", illegal_cycles - ill0, 1);
    check("ill_op_ready", bus.in_ready, 1);
    check("ill_op_valid", bus.out_valid, 0);
    ill0 = illegal_cycles;
    send_byte(8'hC4);
    send_byte(8'hFF);
    repeat (3) @(posedge clk);
    #1;
    check("wide_ill_pulses", illegal_cycles - ill0, 1);
    push(32'hE3A00066, 1'b1);
    send_byte(8'h10);
    send_byte(8'h66);
    wait_idle("after_wide_ill");

    // Reset in the middle of a translation abandons it.
    bus.out_ready = 1'b0;
    send_byte(8'h20);
    send_byte(8'h01);
    send_byte(8'h02);
    wait_out_valid("mid_wait");
    reset = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_word", bus.out_word, 0);
    check("mid_rst_last", bus.out_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tmpl_addr", tmpl_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    push(32'hE3A00077, 1'b1);
    send_byte(8'h10);
    send_byte(8'h77);
    wait_idle("after_mid_rst");

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
